cache_control: RTL and testbench

CACHE_CONTROL -- requirements
Module: cache_control

---
 rtl/cache_control.sv | 192 +++++++++++++++++++
 tb/tb_cache_control.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_control.sv
// cache_control: control FSM for a 2-way set-associative cache with per-set LRU tracking.
//
// On a hit the CPU request completes in the same cycle. On a miss the LRU way of the
// indexed set is chosen as victim. A dirty victim is written back first (S_WB). The line
// is then filled from physical memory (S_ALLOC). The request is then re-evaluated in
// S_IDLE, where it completes as a hit.
//
// Ports
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   mem_read, mem_write         CPU request, held until mem_resp (both high = write)
//   mem_resp                    CPU request complete
//   index                       set index of the current CPU address
//   Hit, Valid, Dirty           per-way status from the datapath
//   pmem_read, pmem_write       physical memory request
//   pmem_resp                   physical memory done
//   write                       per-way array write enable
//   valid_data, dirty_data      values written into the valid / dirty arrays
//   datainmux_sel               line source: 0 = CPU word merge, 1 = pmem_rdata
//   pmem_address_mux_sel        1 = victim (write-back) address, 0 = CPU address
//   basemux_sel                 write-back address way select
//   pmem_wdatamux_sel           write-back data way select
//   hit_count, miss_count       saturating performance counters
//
// Build option
//   CACHE_CTRL_PERF_CNT_EN      when defined, hit_count / miss_count are live counters;
//                               otherwise both are tied to 0 and no counter flops exist.

module cache_control #(
    parameter int unsigned SETS  = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             mem_resp,
    input  logic [IDX_W-1:0] index,
    input  logic [1:0]       Hit,
    input  logic [1:0]       Valid,
    input  logic [1:0]       Dirty,
    output logic             pmem_read,
    output logic             pmem_write,
    input  logic             pmem_resp,
    output logic [1:0]       write,
    output logic             valid_data,
    output logic             dirty_data,
    output logic             datainmux_sel,
    output logic             pmem_address_mux_sel,
    output logic             basemux_sel,
    output logic             pmem_wdatamux_sel,
    output logic [15:0]      hit_count,
    output logic [15:0]      miss_count
);

    typedef enum logic [1:0] {S_IDLE, S_WB, S_ALLOC} state_t;

    state_t          state_q, state_d;
    logic [SETS-1:0] lru_q;       // per set: way to evict next
    logic            victim_q;

    logic req;
    logic hit_way;
    logic lru_way;
    logic hit_done;
    logic miss_start;

    assign req     = mem_read | mem_write;
    assign hit_way = Hit[1];      // way 1 wins when both ways report a hit
    assign lru_way = lru_q[index];

    always_comb begin
        state_d              = state_q;
        mem_resp             = 1'b0;
        pmem_read            = 1'b0;
        pmem_write           = 1'b0;
        write                = 2'b00;
        valid_data           = 1'b0;
        dirty_data           = 1'b0;
        datainmux_sel        = 1'b0;
        pmem_address_mux_sel = 1'b0;
        basemux_sel          = 1'b0;
        pmem_wdatamux_sel    = 1'b0;
        hit_done             = 1'b0;
        miss_start           = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (|Hit) begin
                        mem_resp = 1'b1;
                        hit_done = 1'b1;
                        if (mem_write) begin
                            write      = hit_way ? 2'b10 : 2'b01;
                            valid_data = 1'b1;
                            dirty_data = 1'b1;
                        end
                    end else begin
                        miss_start = 1'b1;
                        state_d    = (Valid[lru_way] && Dirty[lru_way]) ? S_WB : S_ALLOC;
                    end
                end
            end
            S_WB: begin
                pmem_write           = 1'b1;
                pmem_address_mux_sel = 1'b1;
                basemux_sel          = victim_q;
                pmem_wdatamux_sel    = victim_q;
                // An abandoned request still finishes the write-back, but skips the fill.
                if (pmem_resp) begin
                    state_d = req ? S_ALLOC : S_IDLE;
                end
            end
            S_ALLOC: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    write         = victim_q ? 2'b10 : 2'b01;
                    datainmux_sel = 1'b1;
                    valid_data    = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are combinational from inputs too, so hold them quiet during reset.
        if (!rst_n) begin
            mem_resp             = 1'b0;
            pmem_read            = 1'b0;
            pmem_write           = 1'b0;
            write                = 2'b00;
            valid_data           = 1'b0;
            dirty_data           = 1'b0;
            datainmux_sel        = 1'b0;
            pmem_address_mux_sel = 1'b0;
            basemux_sel          = 1'b0;
            pmem_wdatamux_sel    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            lru_q    <= '0;
            victim_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (miss_start) begin
                victim_q <= lru_way;
            end
            if (hit_done) begin
                lru_q[index] <= ~hit_way;
            end
        end
    end

`ifdef CACHE_CTRL_PERF_CNT_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;
    logic        missed_q;    // current request already took a miss

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            missed_q   <= 1'b0;
        end else begin
            if (miss_start) begin
                missed_q <= 1'b1;
                if (miss_cnt_q != 16'hFFFF) begin
                    miss_cnt_q <= miss_cnt_q + 16'd1;
                end
            end
            if (hit_done) begin
                missed_q <= 1'b0;
                if (!missed_q && hit_cnt_q != 16'hFFFF) begin
                    hit_cnt_q <= hit_cnt_q + 16'd1;
                end
            end else if (state_q == S_IDLE && !req) begin
                // Request abandoned during a miss: forget it before the next one.
                missed_q <= 1'b0;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = 16'h0000;
    assign miss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_cache_control.sv
module tb_cache_control;

    localparam int unsigned SETS  = 8;
    localparam int unsigned IDX_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             mem_read = 1'b0;
    logic             mem_write = 1'b0;
    logic             mem_resp;
    logic [IDX_W-1:0] index = '0;
    logic [1:0]       Hit = 2'b00;
    logic [1:0]       Valid = 2'b00;
    logic [1:0]       Dirty = 2'b00;
    logic             pmem_read;
    logic             pmem_write;
    logic             pmem_resp = 1'b0;
    logic [1:0]       write;
    logic             valid_data;
    logic             dirty_data;
    logic             datainmux_sel;
    logic             pmem_address_mux_sel;
    logic             basemux_sel;
    logic             pmem_wdatamux_sel;
    logic [15:0]      hit_count;
    logic [15:0]      miss_count;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: most-recently-used way per set (the victim is the other way),
    // plus expected counter values.
    logic mru_m [SETS];
    int   hits_m = 0;
    int   misses_m = 0;

    cache_control #(
        .SETS (SETS),
        .IDX_W(IDX_W)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .mem_read            (mem_read),
        .mem_write           (mem_write),
        .mem_resp            (mem_resp),
        .index               (index),
        .Hit                 (Hit),
        .Valid               (Valid),
        .Dirty               (Dirty),
        .pmem_read           (pmem_read),
        .pmem_write          (pmem_write),
        .pmem_resp           (pmem_resp),
        .write               (write),
        .valid_data          (valid_data),
        .dirty_data          (dirty_data),
        .datainmux_sel       (datainmux_sel),
        .pmem_address_mux_sel(pmem_address_mux_sel),
        .basemux_sel         (basemux_sel),
        .pmem_wdatamux_sel   (pmem_wdatamux_sel),
        .hit_count           (hit_count),
        .miss_count          (miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed order: mem_resp, write[1:0], valid_data, dirty_data, datainmux_sel,
    // pmem_read, pmem_write, pmem_address_mux_sel, basemux_sel, pmem_wdatamux_sel
    task automatic expect_outs(input string tag, input logic resp, input logic [1:0] wr,
                               input logic vd, input logic dd, input logic ds,
                               input logic prd, input logic pwr, input logic asel,
                               input logic bsel, input logic wsel);
        logic [15:0] obs;
        logic [15:0] exp;
        obs = {5'd0, mem_resp, write, valid_data, dirty_data, datainmux_sel, pmem_read,
               pmem_write, pmem_address_mux_sel, basemux_sel, pmem_wdatamux_sel};
        exp = {5'd0, resp, wr, vd, dd, ds, prd, pwr, asel, bsel, wsel};
        check(tag, obs, exp);
    endtask

    task automatic expect_idle(input string tag);
        expect_outs(tag, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
`ifdef CACHE_CTRL_PERF_CNT_EN
        check({tag, "_hits"}, hit_count, (hits_m > 65535) ? 16'hFFFF : 16'(hits_m));
        check({tag, "_misses"}, miss_count, (misses_m > 65535) ? 16'hFFFF : 16'(misses_m));
`else
        check({tag, "_hits"}, hit_count, 16'h0000);
        check({tag, "_misses"}, miss_count, 16'h0000);
`endif
    endtask

    task automatic model_reset();
        for (int s = 0; s < int'(SETS); s++) mru_m[s] = 1'b1;   // victim way 0 everywhere
        hits_m   = 0;
        misses_m = 0;
    endtask

    // One CPU request from issue to release. drop: 1 = abandon during write-back,
    // 2 = abandon during allocate (only effective if that phase happens).
    task automatic do_request(input logic rd, input logic wr, input logic [IDX_W-1:0] idx,
                              input logic [1:0] hv, input logic [1:0] vl,
                              input logic [1:0] dt, input int lwb, input int lrd,
                              input int drop);
        logic       v;
        logic [1:0] mask;
        mem_read  = rd;
        mem_write = wr;
        index     = idx;
        Hit       = hv;
        Valid     = vl;
        Dirty     = dt;
        pmem_resp = 1'b0;
        #1;
        if (hv != 2'b00) begin
            mask = hv[1] ? 2'b10 : 2'b01;
            expect_outs("hit", 1'b1, wr ? mask : 2'b00, wr, wr, 1'b0,
                        1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            mru_m[idx] = hv[1];
            hits_m++;
        end else begin
            v    = ~mru_m[idx];
            mask = v ? 2'b10 : 2'b01;
            expect_idle("miss_issue");
            tick();
            misses_m++;
            if (vl[v] && dt[v]) begin
                for (int i = 0; i < lwb; i++) begin
                    if (drop == 1 && i == 0) begin
                        mem_read  = 1'b0;
                        mem_write = 1'b0;
                    end
                    pmem_resp = (i == lwb - 1);
                    #1;
                    expect_outs("writeback", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b1, 1'b1, v, v);
                    tick();
                end
                pmem_resp = 1'b0;
            end
            if (mem_read || mem_write) begin
                for (int i = 0; i < lrd; i++) begin
                    if (drop == 2 && i == 0) begin
                        mem_read  = 1'b0;
                        mem_write = 1'b0;
                    end
                    pmem_resp = (i == lrd - 1);
                    #1;
                    if (i == lrd - 1)
                        expect_outs("fill", 1'b0, mask, 1'b1, 1'b0, 1'b1,
                                    1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                    else
                        expect_outs("alloc", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0,
                                    1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                    tick();
                end
                pmem_resp = 1'b0;
                if (mem_read || mem_write) begin
                    Hit = mask;   // datapath now reports the filled way
                    #1;
                    expect_outs("refill_hit", 1'b1, wr ? mask : 2'b00, wr, wr, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                    tick();
                    mru_m[idx] = v;
                end
            end
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        Hit       = 2'b00;
        pmem_resp = 1'b0;
        #1;
        expect_idle("release");
        tick();
    endtask

    initial begin
        logic             rd;
        logic             wr;
        logic [IDX_W-1:0] ridx;
        logic [1:0]       rhv;
        int               sel;

        model_reset();

        // Reset: outputs held at 0 even with a hitting request present.
        mem_read = 1'b1;
        Hit      = 2'b01;
        #2;
        expect_idle("reset_outputs");
        check_counters("reset");
        mem_read = 1'b0;
        Hit      = 2'b00;
        #2 rst_n = 1'b1;
        tick();

        // Read hit on way 0 of set 3: way 1 becomes the victim.
        do_request(1'b1, 1'b0, 3'd3, 2'b01, 2'b11, 2'b00, 1, 1, 0);
        // Write hit on way 1.
        do_request(1'b0, 1'b1, 3'd4, 2'b10, 2'b11, 2'b00, 1, 1, 0);
        // Both ways hit: way 1 wins; read+write together behaves as a write.
        do_request(1'b1, 1'b1, 3'd1, 2'b11, 2'b11, 2'b00, 1, 1, 0);
        // Set 3 miss: victim must be way 1 (dirty) -> write-back with way-1 selects.
        do_request(1'b1, 1'b0, 3'd3, 2'b00, 2'b11, 2'b10, 2, 2, 0);
        // Dirty miss on set 5 (victim 0), 4-cycle write-back, 3-cycle fill.
        do_request(1'b1, 1'b0, 3'd5, 2'b00, 2'b01, 2'b01, 4, 3, 0);
        // Clean miss goes straight to allocate.
        do_request(1'b0, 1'b1, 3'd6, 2'b00, 2'b00, 2'b00, 1, 3, 0);
        // Request dropped during write-back, then during allocate.
        do_request(1'b1, 1'b0, 3'd7, 2'b00, 2'b11, 2'b11, 3, 2, 1);
        do_request(1'b1, 1'b0, 3'd2, 2'b00, 2'b00, 2'b00, 1, 3, 2);
        check_counters("directed");

        // pmem_resp while idle is ignored.
        pmem_resp = 1'b1;
        #1;
        expect_idle("idle_pmem_resp");
        tick();
        pmem_resp = 1'b0;
        #1;
        expect_idle("idle_after_pmem_resp");
        tick();

        // Reset pulsed during allocate.
        mem_read = 1'b1;
        index    = 3'd2;
        Hit      = 2'b00;
        Valid    = 2'b00;
        tick();
        expect_outs("pre_reset_alloc", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0,
                    1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        expect_idle("reset_mid_alloc");
        Hit = 2'b01;
        #1;
        expect_idle("reset_hit_masked");
        model_reset();
        check_counters("reset_mid_alloc");
        rst_n = 1'b1;
        #1;
        expect_outs("post_reset_hit", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        mru_m[2] = 1'b0;
        hits_m++;
        mem_read = 1'b0;
        Hit      = 2'b00;
        #1;
        expect_idle("post_reset_release");
        tick();

        // Three hits and two misses since reset; set 4 lru was cleared (victim 0).
        do_request(1'b1, 1'b0, 3'd0, 2'b10, 2'b00, 2'b00, 1, 1, 0);
        do_request(1'b0, 1'b1, 3'd0, 2'b01, 2'b00, 2'b00, 1, 1, 0);
        do_request(1'b1, 1'b0, 3'd4, 2'b00, 2'b01, 2'b01, 2, 2, 0);
        do_request(1'b1, 1'b0, 3'd2, 2'b00, 2'b10, 2'b10, 1, 2, 0);
        check_counters("three_two");

        // Randomized traffic against the model.
        for (int n = 0; n < 60; n++) begin
            rd   = 1'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1'b1;
            ridx = IDX_W'($urandom_range(0, SETS - 1));
            rhv  = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            sel  = $urandom_range(0, 5);
            do_request(rd, wr, ridx, rhv, 2'($urandom_range(0, 3)),
                       2'($urandom_range(0, 3)), $urandom_range(1, 4),
                       $urandom_range(1, 4), (sel < 4) ? 0 : sel - 3);
        end
        check_counters("random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
